// File: rtl/sevenseg_capture_pkg.sv
// rtl/sevenseg_capture_pkg.sv - seven-segment encoding shared with the display driver
package sevenseg_capture_pkg;

  // Segment bit order on the bus: bit0=a ... bit6=g, active-high
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [3:0] BLANK_CODE = 4'd12;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A_HEX = 7'h77;
  localparam logic [6:0] SEG_B_HEX = 7'h7C;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_D_HEX = 7'h5E;
  localparam logic [6:0] SEG_E_HEX = 7'h79;
  localparam logic [6:0] SEG_F_HEX = 7'h71;

  // Forward encoding; the capture path inverts it by search
  function automatic logic [6:0] seg_encode(input logic [3:0] code);
    case (code)
      4'd0:       seg_encode = SEG_0;
      4'd1:       seg_encode = SEG_1;
      4'd2:       seg_encode = SEG_2;
      4'd3:       seg_encode = SEG_3;
      4'd4:       seg_encode = SEG_4;
      4'd5:       seg_encode = SEG_5;
      4'd6:       seg_encode = SEG_6;
      4'd7:       seg_encode = SEG_7;
      4'd8:       seg_encode = SEG_8;
      4'd9:       seg_encode = SEG_9;
      4'd10:      seg_encode = SEG_A_HEX;
      4'd11:      seg_encode = SEG_B_HEX;
      BLANK_CODE: seg_encode = SEG_BLANK;
      4'd13:      seg_encode = SEG_D_HEX;
      4'd14:      seg_encode = SEG_E_HEX;
      default:    seg_encode = SEG_F_HEX;
    endcase
  endfunction

endpackage

// File: rtl/sevenseg_capture_decode.sv
// rtl/sevenseg_capture_decode.sv - combinational 7-bit pattern to {value, err}
module sevenseg_decode
  import sevenseg_capture_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       err
);

  // Reverse lookup over the 16 legal codes; anything else is flagged with value 0
  always_comb begin
    value = 4'd0;
    err   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (pattern == seg_encode(4'(i))) begin
        value = 4'(i);
        err   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sevenseg_capture.sv
// rtl/sevenseg_capture.sv - synchronise, qualify and decode a 7-seg bus; option SEVENSEG_CAPTURE_INVERT_EN
module sevenseg_capture
  import sevenseg_capture_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       seg_in,
  input  logic             clr,
  input  logic             ready,
  output logic             valid,
  output logic [3:0]       value,
  output logic             err,
  output logic             overrun,
  output logic [CNT_W-1:0] event_count
);

  localparam logic [7:0] STAB_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);

  logic [6:0] seg_pin;
  logic [6:0] sync1;
  logic [6:0] s;
  logic [6:0] s_prev;
  logic [7:0] stab_cnt;
  logic [6:0] last_reported;
  logic [3:0] dec_value;
  logic       dec_err;
  logic       accept;

`ifdef SEVENSEG_CAPTURE_INVERT_EN
  // Common-anode displays drive segments low; normalise before synchronising
  assign seg_pin = ~seg_in;
`else
  assign seg_pin = seg_in;
`endif

  // Two-flop synchroniser plus a delayed copy for change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      s      <= '0;
      s_prev <= '0;
    end else begin
      sync1  <= seg_pin;
      s      <= sync1;
      s_prev <= s;
    end
  end

  // Stability counter: restarts on any change, saturates once the pattern is qualified
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt <= '0;
    end else if (s != s_prev) begin
      stab_cnt <= '0;
    end else if (stab_cnt != STAB_MAX) begin
      stab_cnt <= stab_cnt + 8'd1;
    end
  end

  // Saturation guarantees a single accept per stable period; repeats of the last pattern are ignored
  assign accept = (s == s_prev) && (stab_cnt == STAB_LAST) && (s != last_reported);

  sevenseg_decode u_decode (
    .pattern (s),
    .value   (dec_value),
    .err     (dec_err)
  );

  // Remember the last accepted pattern so a re-stabilised copy makes no event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reported <= SEG_BLANK;
    end else if (accept) begin
      last_reported <= s;
    end
  end

  // One-entry holding register; a new accept always wins over the consumer's pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      value <= 4'd0;
      err   <= 1'b0;
    end else if (accept) begin
      valid <= 1'b1;
      value <= dec_value;
      err   <= dec_err;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  // Overrun is sticky; an overwrite in the clear cycle still sets it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (accept && valid && !ready) begin
      overrun <= 1'b1;
    end else if (clr) begin
      overrun <= 1'b0;
    end
  end

  // Event counter wraps; an accept in the clear cycle counts as the first event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_count <= '0;
    end else if (accept) begin
      event_count <= clr ? CNT_W'(1) : event_count + CNT_W'(1);
    end else if (clr) begin
      event_count <= '0;
    end
  end

endmodule
